// File: rtl/regfile.sv
// regfile: 32x64 register file, two async read ports, one sync write port, X31 reads zero.
// Optional write-through bypass of WriteData to matching read ports under REGFILE_BYPASS_EN.
module regfile_dec (
  input  logic        en_i,
  input  logic [4:0]  sel_i,
  output logic [31:0] dec_o
);
  assign dec_o = en_i ? (32'd1 << sel_i) : '0;
endmodule

module regfile_mux32 #(
  parameter int W = 64
) (
  input  logic [4:0]         sel_i,
  input  logic [31:0][W-1:0] d_i,
  output logic [W-1:0]       y_o
);
  logic [7:0][W-1:0] l1;
  logic [1:0][W-1:0] l2;
  for (genvar g = 0; g < 8; g++) begin : g_l1
    localparam logic [2:0] G = g;
    assign l1[g] = d_i[{G, sel_i[1:0]}];
  end
  for (genvar g = 0; g < 2; g++) begin : g_l2
    localparam logic G = g;
    assign l2[g] = l1[{G, sel_i[3:2]}];
  end
  assign y_o = sel_i[4] ? l2[1] : l2[0];
endmodule

module regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);
  logic [NUM_REGS-1:0]                 we;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rows;
  logic [DATA_WIDTH-1:0]               rd1, rd2;
  logic                                unused_zr;
  regfile_dec u_dec (.en_i(RegWrite), .sel_i(WriteRegister), .dec_o(we));
  assign unused_zr = we[ZERO_REG];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_row
    if (i == ZERO_REG) begin : g_zr
      assign rows[i] = '0;
    end else begin : g_ff
      logic [DATA_WIDTH-1:0] row_q, row_d;
      assign row_d = we[i] ? WriteData : row_q;
      always_ff @(posedge clk or posedge reset)
        if (reset) row_q <= '0;
        else row_q <= row_d;
      assign rows[i] = row_q;
    end
  end
  regfile_mux32 #(.W(DATA_WIDTH)) u_mux1 (.sel_i(ReadRegister1), .d_i(rows), .y_o(rd1));
  regfile_mux32 #(.W(DATA_WIDTH)) u_mux2 (.sel_i(ReadRegister2), .d_i(rows), .y_o(rd2));
`ifdef REGFILE_BYPASS_EN
  logic wr_ok, byp1, byp2;
  assign wr_ok     = RegWrite && !reset && (WriteRegister != 5'(ZERO_REG));
  assign byp1      = wr_ok && (WriteRegister == ReadRegister1);
  assign byp2      = wr_ok && (WriteRegister == ReadRegister2);
  assign ReadData1 = byp1 ? WriteData : rd1;
  assign ReadData2 = byp2 ? WriteData : rd2;
`else
  assign ReadData1 = rd1;
  assign ReadData2 = rd2;
`endif
endmodule
